shadow_regfile: RTL

SHADOW_REGFILE -- requirements
Module: shadow_regfile

---
 rtl/shadow_regfile.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/shadow_regfile.sv
// rtl/shadow_regfile.sv - LED timing register file with staged/active register sets
//
// Define SHADOW_REGFILE_DBUF_EN to build the double-buffered variant. Without it,
// register writes land directly in the active set and no staging storage exists.
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset
//   reg_rd_addr_i  - read address (0..7)
//   reg_wr_en_i    - write strobe
//   reg_wr_addr_i  - write address (0..7)
//   reg_wr_data_i  - write data
//   frame_idle_i   - output engine is between frames
//   reg_t0h_time_o - active T0 high time
//   reg_t0s_time_o - active T0 high + low time
//   reg_t1h_time_o - active T1 high time
//   reg_t1s_time_o - active T1 high + low time
//   reg_chan_len_o - active channel length
//   reg_chan_cnt_o - active channel count
//   reg_update_o   - one-cycle pulse after the active set changes
//   reg_rd_data_o  - registered read data

module shadow_regfile #(
    parameter int DATA_W   = 8,
    parameter int CHAN_NUM = 16,
    localparam int CNT_W   = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        reg_rd_addr_i,
    input  logic              reg_wr_en_i,
    input  logic [2:0]        reg_wr_addr_i,
    input  logic [DATA_W-1:0] reg_wr_data_i,
    input  logic              frame_idle_i,
    output logic [DATA_W-1:0] reg_t0h_time_o,
    output logic [DATA_W:0]   reg_t0s_time_o,
    output logic [DATA_W-1:0] reg_t1h_time_o,
    output logic [DATA_W:0]   reg_t1s_time_o,
    output logic [DATA_W-1:0] reg_chan_len_o,
    output logic [CNT_W-1:0]  reg_chan_cnt_o,
    output logic              reg_update_o,
    output logic [DATA_W-1:0] reg_rd_data_o
);

    localparam logic [2:0] ADDR_T0H  = 3'd0;
    localparam logic [2:0] ADDR_T0L  = 3'd1;
    localparam logic [2:0] ADDR_T1H  = 3'd2;
    localparam logic [2:0] ADDR_T1L  = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [2:0] ADDR_CNT  = 3'd5;
    localparam logic [2:0] ADDR_CTRL = 3'd6;

    logic [DATA_W-1:0] act_t0h, act_t0l, act_t1h, act_t1l, act_len;
    logic [CNT_W-1:0]  act_cnt;
    logic              update_q;

    // Values seen by register reads of addresses 0-5.
    logic [DATA_W-1:0] src_t0h, src_t0l, src_t1h, src_t1l, src_len;
    logic [CNT_W-1:0]  src_cnt;
    logic              status_pending;

`ifdef SHADOW_REGFILE_DBUF_EN
    logic [DATA_W-1:0] st_t0h, st_t0l, st_t1h, st_t1l, st_len;
    logic [CNT_W-1:0]  st_cnt;
    logic              pending;
    logic              copy;
    logic              commit_req;

    assign copy       = pending && frame_idle_i;
    assign commit_req = reg_wr_en_i && (reg_wr_addr_i == ADDR_CTRL) && reg_wr_data_i[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_t0h <= '0;
            st_t0l <= '0;
            st_t1h <= '0;
            st_t1l <= '0;
            st_len <= '0;
            st_cnt <= '0;
        end else if (reg_wr_en_i) begin
            case (reg_wr_addr_i)
                ADDR_T0H: st_t0h <= reg_wr_data_i;
                ADDR_T0L: st_t0l <= reg_wr_data_i;
                ADDR_T1H: st_t1h <= reg_wr_data_i;
                ADDR_T1L: st_t1l <= reg_wr_data_i;
                ADDR_LEN: st_len <= reg_wr_data_i;
                ADDR_CNT: st_cnt <= reg_wr_data_i[CNT_W-1:0];
                default:  ;
            endcase
        end
    end

    // The copy samples staging before this edge's write, so a same-edge write stays staged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_t0h <= '0;
            act_t0l <= '0;
            act_t1h <= '0;
            act_t1l <= '0;
            act_len <= '0;
            act_cnt <= '0;
        end else if (copy) begin
            act_t0h <= st_t0h;
            act_t0l <= st_t0l;
            act_t1h <= st_t1h;
            act_t1l <= st_t1l;
            act_len <= st_len;
            act_cnt <= st_cnt;
        end
    end

    // A fresh request on the copy edge takes priority so it is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            update_q <= copy;
            if (commit_req) begin
                pending <= 1'b1;
            end else if (copy) begin
                pending <= 1'b0;
            end
        end
    end

    assign src_t0h        = st_t0h;
    assign src_t0l        = st_t0l;
    assign src_t1h        = st_t1h;
    assign src_t1l        = st_t1l;
    assign src_len        = st_len;
    assign src_cnt        = st_cnt;
    assign status_pending = pending;
`else
    logic cfg_write;

    assign cfg_write = reg_wr_en_i && (reg_wr_addr_i <= ADDR_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_t0h  <= '0;
            act_t0l  <= '0;
            act_t1h  <= '0;
            act_t1l  <= '0;
            act_len  <= '0;
            act_cnt  <= '0;
            update_q <= 1'b0;
        end else begin
            update_q <= cfg_write;
            if (reg_wr_en_i) begin
                case (reg_wr_addr_i)
                    ADDR_T0H: act_t0h <= reg_wr_data_i;
                    ADDR_T0L: act_t0l <= reg_wr_data_i;
                    ADDR_T1H: act_t1h <= reg_wr_data_i;
                    ADDR_T1L: act_t1l <= reg_wr_data_i;
                    ADDR_LEN: act_len <= reg_wr_data_i;
                    ADDR_CNT: act_cnt <= reg_wr_data_i[CNT_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    assign src_t0h        = act_t0h;
    assign src_t0l        = act_t0l;
    assign src_t1h        = act_t1h;
    assign src_t1l        = act_t1l;
    assign src_len        = act_len;
    assign src_cnt        = act_cnt;
    assign status_pending = 1'b0;
`endif

    logic [DATA_W-1:0] rd_next;

    always_comb begin
        rd_next = '0;
        case (reg_rd_addr_i)
            ADDR_T0H: rd_next = src_t0h;
            ADDR_T0L: rd_next = src_t0l;
            ADDR_T1H: rd_next = src_t1h;
            ADDR_T1L: rd_next = src_t1l;
            ADDR_LEN: rd_next = src_len;
            ADDR_CNT: rd_next[CNT_W-1:0] = src_cnt;
            ADDR_CTRL: rd_next = '0;
            default: begin
                rd_next[0] = status_pending;
                rd_next[1] = frame_idle_i;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_rd_data_o <= '0;
        end else begin
            reg_rd_data_o <= rd_next;
        end
    end

    assign reg_t0h_time_o = act_t0h;
    assign reg_t0s_time_o = {1'b0, act_t0h} + {1'b0, act_t0l};
    assign reg_t1h_time_o = act_t1h;
    assign reg_t1s_time_o = {1'b0, act_t1h} + {1'b0, act_t1l};
    assign reg_chan_len_o = act_len;
    assign reg_chan_cnt_o = act_cnt;
    assign reg_update_o   = update_q;

endmodule
